// File: rtl/scan_pkg.sv
// Shared constants and helpers for the scanning shift register.
package scan_pkg;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_SERIAL = 1'b1;
  localparam logic DIR_LEFT    = 1'b0;
  localparam logic DIR_RIGHT   = 1'b1;

  // All ones across the low 'width' bits except bit 0: a single walking zero.
  function automatic logic [63:0] reset_pattern(input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return mask & ~64'd1;
  endfunction

endpackage

// File: rtl/scan_shr_tick_gen.sv
// Prescaler: strobes tick once every DIV enabled cycles; clr restarts the count.
module tick_gen #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Gated by rst so no strobe escapes while reset is held (matters for DIV=1).
  assign tick = rst & en & ~clr & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_shr.sv
// Prescaled rotate/serial shift register with a position counter tracking the shift.
module scan_shr
  import scan_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 16,
  parameter int unsigned PW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             si,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    pos,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_Q    = WIDTH'(reset_pattern(WIDTH));
  localparam logic [PW-1:0]    POS_LAST = PW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             fill;

  // load doubles as the prescaler clear, so tick is already suppressed on load cycles.
  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .tick(tick)
  );

  always_comb begin
    if (mode == MODE_SERIAL) begin
      fill = si;
    end else begin
      fill = (dir == DIR_LEFT) ? q_q[WIDTH-1] : q_q[0];
    end

    q_d   = q_q;
    pos_d = pos_q;
    if (load) begin
      q_d   = load_val;
      pos_d = '0;
    end else if (tick) begin
      if (dir == DIR_LEFT) begin
        q_d   = {q_q[WIDTH-2:0], fill};
        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
      end else begin
        q_d   = {fill, q_q[WIDTH-1:1]};
        pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
      end
    end

    wrap = tick & ((dir == DIR_LEFT) ? (pos_q == POS_LAST) : (pos_q == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= RST_Q;
      pos_q <= '0;
    end else begin
      q_q   <= q_d;
      pos_q <= pos_d;
    end
  end

  assign q   = q_q;
  assign pos = pos_q;

endmodule

// File: tb/tb_scan_shr.sv
// Bench for scan_shr: DIV=4 and DIV=1 instances against a behavioural model.
module tb_scan_shr;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, mode = 1'b0, dir = 1'b0, si = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q0, q1;
  logic [1:0] pos0, pos1;
  logic       tick0, tick1, wrap0, wrap1;

  always #5 clk = ~clk;

  scan_shr #(.WIDTH(4), .DIV(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .si(si), .load(load),
    .load_val(load_val), .q(q0), .pos(pos0), .tick(tick0), .wrap(wrap0)
  );

  scan_shr #(.WIDTH(4), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .si(si), .load(load),
    .load_val(load_val), .q(q1), .pos(pos1), .tick(tick1), .wrap(wrap1)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference state per instance: register value, position, prescale count.
  int m_q[2];
  int m_pos[2];
  int m_cnt[2];
  int divs[2] = '{4, 1};

  typedef struct {
    logic       en, mode, dir, si, load;
    logic [3:0] lv;
    logic [3:0] eq;
    int         epos;
    logic       etick, ewrap;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int m_tick(input int i);
    return (rst && en && !load && m_cnt[i] == divs[i] - 1) ? 1 : 0;
  endfunction

  function automatic int m_wrap(input int i);
    return (m_tick(i) != 0 && ((dir == 1'b0 && m_pos[i] == W - 1) ||
                               (dir == 1'b1 && m_pos[i] == 0))) ? 1 : 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = ((1 << W) - 1) & ~1;
      m_pos[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic m_edge();
    int f;
    for (int i = 0; i < 2; i++) begin
      if (load) begin
        m_q[i] = int'(load_val);
        m_pos[i] = 0;
        m_cnt[i] = 0;
      end else if (en) begin
        if (m_tick(i) != 0) begin
          if (dir == 1'b0) begin
            f = mode ? int'(si) : (m_q[i] >> (W - 1)) & 1;
            m_q[i] = ((m_q[i] << 1) | f) & ((1 << W) - 1);
            m_pos[i] = (m_pos[i] + 1) % W;
          end else begin
            f = mode ? int'(si) : m_q[i] & 1;
            m_q[i] = (m_q[i] >> 1) | (f << (W - 1));
            m_pos[i] = (m_pos[i] + W - 1) % W;
          end
        end
        m_cnt[i] = (m_cnt[i] + 1) % divs[i];
      end
    end
  endtask

  task automatic check_comb();
    chk("tick0", int'(tick0), m_tick(0));
    chk("wrap0", int'(wrap0), m_wrap(0));
    chk("tick1", int'(tick1), m_tick(1));
    chk("wrap1", int'(wrap1), m_wrap(1));
  endtask

  task automatic check_regs();
    chk("q0", int'(q0), m_q[0]);
    chk("pos0", int'(pos0), m_pos[0]);
    chk("q1", int'(q1), m_q[1]);
    chk("pos1", int'(pos1), m_pos[1]);
  endtask

  // Entered just after a falling edge with inputs already driven.
  task automatic run_cycle();
    #1 check_comb();
    @(posedge clk);
    m_edge();
    #1 check_regs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1 m_reset();
    check_regs();
    check_comb();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic add(input int n, input logic e, input logic md, input logic dr,
                     input logic s, input logic ld, input logic [3:0] lv,
                     input logic [3:0] eq, input int ep, input logic et, input logic ew);
    vec_t v;
    v.en = e; v.mode = md; v.dir = dr; v.si = s; v.load = ld; v.lv = lv;
    v.eq = eq; v.epos = ep; v.etick = et; v.ewrap = ew;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    // Rotate left from reset, then a mid-prescale load, a hold cycle, and the next tick.
    add(3, 1, 0, 0, 0, 0, 4'h0, 4'b1110, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4'h0, 4'b1101, 1, 1, 0);
    add(3, 1, 0, 0, 0, 0, 4'h0, 4'b1101, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4'h0, 4'b1011, 2, 1, 0);
    add(3, 1, 0, 0, 0, 0, 4'h0, 4'b1011, 2, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4'h0, 4'b0111, 3, 1, 0);
    add(3, 1, 0, 0, 0, 0, 4'h0, 4'b0111, 3, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4'h0, 4'b1110, 0, 1, 1);
    add(3, 1, 0, 0, 0, 0, 4'h0, 4'b1110, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1, 4'b1010, 4'b1010, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 4'h0, 4'b1010, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 4'h0, 4'b1010, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4'h0, 4'b0101, 1, 1, 0);

    @(negedge clk);
    do_reset();

    foreach (tbl[k]) begin
      en = tbl[k].en; mode = tbl[k].mode; dir = tbl[k].dir;
      si = tbl[k].si; load = tbl[k].load; load_val = tbl[k].lv;
      #1 chk($sformatf("tbl%0d_tick", k), int'(tick0), int'(tbl[k].etick));
      chk($sformatf("tbl%0d_wrap", k), int'(wrap0), int'(tbl[k].ewrap));
      check_comb();
      @(posedge clk);
      m_edge();
      #1 chk($sformatf("tbl%0d_q", k), int'(q0), int'(tbl[k].eq));
      chk($sformatf("tbl%0d_pos", k), int'(pos0), tbl[k].epos);
      check_regs();
      @(negedge clk);
    end
    load = 1'b0;

    // Rotate right from reset: the first tick wraps to pos 3.
    do_reset();
    en = 1'b1; mode = 1'b0; dir = 1'b1;
    repeat (3) run_cycle();
    #1 chk("right_tick", int'(tick0), 1);
    chk("right_wrap", int'(wrap0), 1);
    @(posedge clk);
    m_edge();
    #1 chk("right_q", int'(q0), 4'b0111);
    chk("right_pos", int'(pos0), 3);
    @(negedge clk);

    // Serial fill left with si=1 then si=0.
    do_reset();
    en = 1'b1; mode = 1'b1; dir = 1'b0; si = 1'b1;
    repeat (4) run_cycle();
    chk("serial_q1", int'(q0), 4'b1101);
    si = 1'b0;
    repeat (4) run_cycle();
    chk("serial_q2", int'(q0), 4'b1010);

    // Asynchronous reset between edges while q=1011.
    do_reset();
    en = 1'b1; mode = 1'b0; dir = 1'b0;
    repeat (8) run_cycle();
    chk("pre_async_q", int'(q0), 4'b1011);
    #2 rst = 1'b0;
    #1 chk("async_q", int'(q0), 4'b1110);
    chk("async_pos", int'(pos0), 0);
    chk("async_tick1", int'(tick1), 0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;

    // Randomised traffic including occasional loads and mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) begin
        #2 rst = 1'b0;
        #1 m_reset();
        check_regs();
        check_comb();
        @(negedge clk);
        rst = 1'b1;
      end
      en = ($urandom_range(9) < 7);
      mode = 1'($urandom);
      dir = 1'($urandom);
      si = 1'($urandom);
      load = ($urandom_range(19) == 0);
      load_val = 4'($urandom);
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scan_shr.md
SCAN_SHR -- requirements
Module: scan_shr

Interface
REQ-001 Parameter WIDTH, default 4: number of register bits / display positions; WIDTH >= 2.
REQ-002 Parameter DIV, default 16: prescaler period in enabled clock cycles; DIV >= 1.
REQ-003 Parameter PW, default $clog2(WIDTH): width of pos.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  prescaler/shift enable.
REQ-007 mode  input  1  0 = rotate (circular), 1 = serial (fill from si).
REQ-008 dir  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB).
REQ-009 si  input  1  serial fill bit, used only when mode=1.
REQ-010 load  input  1  synchronous parallel load strobe.
REQ-011 load_val  input  WIDTH  parallel load value.
REQ-012 q  output  WIDTH  register contents, registered.
REQ-013 pos  output  PW  position counter modulo WIDTH, registered.
REQ-014 tick  output  1  prescaler strobe; the shift occurs on the same rising edge.
REQ-015 wrap  output  1  asserted with tick when pos wraps.

Function
REQ-016 Prescaler counter cnt counts 0..DIV-1, increments only while en=1 and load=0, and returns to 0 after DIV-1.
REQ-017 tick = en & ~load & (cnt == DIV-1), combinational; with DIV=1, tick equals en & ~load.
REQ-018 On a tick edge with dir=0: q <= {q[WIDTH-2:0], f}; pos <= (pos == WIDTH-1) ? 0 : pos+1.
REQ-019 On a tick edge with dir=1: q <= {f, q[WIDTH-1:1]}; pos <= (pos == 0) ? WIDTH-1 : pos-1.
REQ-020 Fill bit f = q[WIDTH-1] for dir=0 or q[0] for dir=1 when mode=0; f = si when mode=1.
REQ-021 wrap = tick & ((dir=0 & pos==WIDTH-1) | (dir=1 & pos==0)).
REQ-022 load=1: q <= load_val, pos <= 0, cnt <= 0 regardless of en; load has priority over tick, so tick and wrap are 0 that cycle.
REQ-023 With en=0 and load=0, q, pos and cnt hold.
REQ-024 Changes to dir, mode or si are sampled only on tick edges; no glitch or extra shift results.
REQ-025 In rotate mode, starting from the reset pattern, exactly one bit of q is 0 and pos equals its index.

Reset
REQ-026 rst=0 asynchronously forces q = all ones except q[0] = 0 (WIDTH=4: 1110), pos = 0 and cnt = 0; tick and wrap are 0 while reset is held.
REQ-027 Reset asserted mid-prescale or mid-shift takes effect immediately without waiting for a clock edge.
REQ-028 After rst deasserts, the first tick occurs DIV enabled cycles later.

Structure
REQ-029 Shared package scan_pkg holds MODE_ROTATE=0, MODE_SERIAL=1, DIR_LEFT=0, DIR_RIGHT=1 and a reset-pattern function of WIDTH.
REQ-030 The prescaler is one sub-module, tick_gen (parameter DIV; ports clk, rst, en, clr, tick).
REQ-031 No other sub-modules; the shift register and pos logic live in scan_shr.

Verification (WIDTH=4, DIV=4 unless stated)
REQ-032 Hold rst=0, then release -> q=1110, pos=0, tick=0; first tick on the 4th enabled cycle.
REQ-033 mode=0, dir=0, en=1 for 16 cycles -> q 1110->1101->1011->0111->1110, pos 0->1->2->3->0, wrap only on the 4th tick.
REQ-034 mode=0, dir=1 from reset -> first tick gives q=0111, pos=3 and wrap=1.
REQ-035 mode=1, dir=0, si=1 then si=0 on successive ticks -> q 1110->1101->1010.
REQ-036 load=1 with load_val=1010 on a cycle where cnt=3 and en=1 -> tick=0, q=1010, pos=0, cnt=0; next tick is 4 cycles later.
REQ-037 Assert rst=0 between clock edges while q=1011 -> q=1110 before the next edge; DIV=1 variant -> tick every enabled cycle.
